// File: rtl/rhs_pkg.sv
// Shared constants and types for the RHS SPI chip emulator.
package rhs_pkg;

  localparam int unsigned CHANNELS_PER_CHIP = 16;
  localparam int unsigned FRAME_BITS        = 32;
  localparam int unsigned CNT_W             = 6;
  localparam logic [7:0]  REG_CHIP_ID_ADDR  = 8'd255;
  localparam logic [7:0]  CLEAR_KEY         = 8'h6A;

  typedef enum logic [1:0] {
    OP_CONVERT = 2'b00,
    OP_CLEAR   = 2'b01,
    OP_WRITE   = 2'b10,
    OP_READ    = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  // Per-clk framing events broadcast from the top to every chip.
  typedef struct packed {
    logic cs_fall;
    logic sclk_rise;
    logic sclk_fall;
    logic accept;
    logic active;
  } frame_ev_t;

endpackage

// File: rtl/rhs_spi_emu_chip.sv
// One emulated chip: shift registers, command decode, register file,
// per-channel sample counters and the result pipeline.
module rhs_spi_emu_chip
  import rhs_pkg::*;
#(
  parameter int unsigned CHIP_IDX    = 0,
  parameter int unsigned SEED_STRIDE = 16,
  parameter int unsigned PIPE_DEPTH  = 2,
  parameter int unsigned REG_DEPTH   = 32,
  parameter logic [15:0] CHIP_ID     = 16'h0020
) (
  input  logic       clk,
  input  logic       rst,
  input  frame_ev_t  ev_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic [5:0] channel_o
);

  localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int unsigned PW = PIPE_DEPTH * FRAME_BITS;

  logic [31:0]                       in_sr_q;
  logic [31:0]                       out_sr_q;
  logic                              miso_q;
  logic [PW-1:0]                     pipe_q;
  logic [5:0]                        chan_q;
  logic [REG_DEPTH*16-1:0]           regs_flat;
  logic [CHANNELS_PER_CHIP*16-1:0]   samp_flat;

  opcode_e     op;
  logic [7:0]  addr;
  logic [5:0]  ch;
  logic [15:0] data;
  logic [31:0] result_c;
  logic        conv_c;
  logic        wr_c;
  logic        clr_c;

  assign op   = opcode_e'(in_sr_q[31:30]);
  assign addr = in_sr_q[23:16];
  assign ch   = in_sr_q[21:16];
  assign data = in_sr_q[15:0];

  // Decode the frame just shifted in; the result is what it will return.
  always_comb begin
    result_c = '0;
    conv_c   = 1'b0;
    wr_c     = 1'b0;
    clr_c    = 1'b0;
    case (op)
      OP_CONVERT: begin
        if (ch < 6'(CHANNELS_PER_CHIP)) begin
          conv_c   = 1'b1;
          result_c = {16'h0000, samp_flat[{ch[3:0], 4'b0000} +: 16]};
        end
      end
      OP_WRITE: begin
        result_c = {16'hFFFF, data};
        wr_c     = (addr < 8'(REG_DEPTH));
      end
      OP_READ: begin
        if (addr == REG_CHIP_ID_ADDR) begin
          result_c = {16'h0000, CHIP_ID};
        end else if (addr < 8'(REG_DEPTH)) begin
          result_c = {16'h0000, regs_flat[{addr[AW-1:0], 4'b0000} +: 16]};
        end
      end
      OP_CLEAR: begin
        clr_c = (in_sr_q[31:24] == CLEAR_KEY);
      end
      default: ;
    endcase
  end

  for (genvar r = 0; r < REG_DEPTH; r++) begin : g_reg
    logic [15:0] reg_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        reg_q <= '0;
      end else if (ev_i.accept && wr_c && (addr[AW-1:0] == AW'(r))) begin
        reg_q <= data;
      end
    end
    assign regs_flat[r*16 +: 16] = reg_q;
  end

  for (genvar s = 0; s < CHANNELS_PER_CHIP; s++) begin : g_samp
    localparam logic [15:0] SEED = 16'(CHIP_IDX * SEED_STRIDE + s);
    logic [15:0] samp_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        samp_q <= SEED;
      end else if (ev_i.accept && clr_c) begin
        samp_q <= SEED;
      end else if (ev_i.accept && conv_c && (ch[3:0] == 4'(s))) begin
        samp_q <= samp_q + 16'd1;
      end
    end
    assign samp_flat[s*16 +: 16] = samp_q;
  end

  // Oldest pipeline entry sits at the top and is loaded into the output shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_sr_q  <= '0;
      out_sr_q <= '0;
      miso_q   <= 1'b0;
      pipe_q   <= '0;
      chan_q   <= '0;
    end else begin
      if (ev_i.sclk_rise) begin
        in_sr_q <= {in_sr_q[30:0], mosi_i};
      end
      if (ev_i.cs_fall) begin
        out_sr_q <= pipe_q[PW-1 -: 32];
        miso_q   <= pipe_q[PW-1];
      end else if (ev_i.sclk_fall) begin
        out_sr_q <= {out_sr_q[30:0], 1'b0};
        miso_q   <= out_sr_q[30];
      end else if (!ev_i.active) begin
        miso_q <= 1'b0;
      end
      if (ev_i.accept) begin
        pipe_q <= PW'({pipe_q, result_c});
        if (conv_c) begin
          chan_q <= ch;
        end
      end
    end
  end

  assign miso_o    = miso_q;
  assign channel_o = chan_q;

endmodule

// File: rtl/rhs_spi_emulator.sv
// Multi-chip RHS SPI slave emulator: input synchronisers, bit counting and
// frame accept/discard, with one rhs_spi_emu_chip per MOSI/MISO pair.
module rhs_spi_emulator
  import rhs_pkg::*;
#(
  parameter int unsigned N_CHIPS     = 16,
  parameter int unsigned SEED_STRIDE = 16,
  parameter int unsigned PIPE_DEPTH  = 2,
  parameter int unsigned REG_DEPTH   = 32,
  parameter logic [15:0] CHIP_ID     = 16'h0020
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCLK,
  input  logic                 CS,
  input  logic [N_CHIPS-1:0]   MOSI,
  output logic [N_CHIPS-1:0]   MISO,
  output logic [N_CHIPS*6-1:0] channel_out,
  output logic                 frame_done,
  output logic                 frame_err
);

  logic [2:0]         sclk_q;
  logic [2:0]         cs_q;
  logic [N_CHIPS-1:0] mosi_s1_q;
  logic [N_CHIPS-1:0] mosi_s2_q;
  frame_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  frame_ev_t          ev_c;
  logic               sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;

  // Bit [1] is the synchronised level, bit [2] its previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= '0;
      cs_q      <= '0;
      mosi_s1_q <= '0;
      mosi_s2_q <= '0;
    end else begin
      sclk_q    <= {sclk_q[1:0], SCLK};
      cs_q      <= {cs_q[1:0], CS};
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise_c = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_c = ~sclk_q[1] & sclk_q[2];
  assign cs_fall_c   = ~cs_q[1] & cs_q[2];
  assign cs_rise_c   = cs_q[1] & ~cs_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // A frame only exists between a seen CS fall and the next CS rise, so a
  // reset mid-frame leaves nothing to judge when CS finally rises.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ev_c    = '0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_c) begin
          state_d      = ST_ACTIVE;
          cnt_d        = '0;
          ev_c.cs_fall = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_c) begin
          state_d = ST_IDLE;
          if (cnt_q == CNT_W'(FRAME_BITS)) begin
            ev_c.accept = 1'b1;
            done_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          ev_c.active    = 1'b1;
          ev_c.sclk_rise = sclk_rise_c;
          ev_c.sclk_fall = sclk_fall_c;
          if (sclk_rise_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_done = done_q;
  assign frame_err  = err_q;

  for (genvar g = 0; g < N_CHIPS; g++) begin : g_chip
    rhs_spi_emu_chip #(
      .CHIP_IDX   (g),
      .SEED_STRIDE(SEED_STRIDE),
      .PIPE_DEPTH (PIPE_DEPTH),
      .REG_DEPTH  (REG_DEPTH),
      .CHIP_ID    (CHIP_ID)
    ) u_chip (
      .clk      (clk),
      .rst      (rst),
      .ev_i     (ev_c),
      .mosi_i   (mosi_s2_q[g]),
      .miso_o   (MISO[g]),
      .channel_o(channel_out[g*6 +: 6])
    );
  end

endmodule

// File: tb/tb_rhs_spi_emulator.sv
// Scoreboard bench: three emulator configurations share SCLK/CS/MOSI and are
// checked against a behavioural model of samples, registers and pipeline.
module tb_rhs_spi_emulator;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        sclk = 1'b0;
  logic        cs   = 1'b1;
  logic [15:0] mosi = '0;

  logic [15:0] miso_a;
  logic [3:0]  miso_b, miso_c;
  logic [95:0] chan_a;
  logic [23:0] chan_b, chan_c;
  logic        fd_a, fe_a, fd_b, fe_b, fd_c, fe_c;

  always #5 clk = ~clk;

  rhs_spi_emulator #(.N_CHIPS(16), .SEED_STRIDE(16), .PIPE_DEPTH(2), .REG_DEPTH(32),
                     .CHIP_ID(16'h0020)) dut_a (
    .clk(clk), .rst(rst), .SCLK(sclk), .CS(cs), .MOSI(mosi), .MISO(miso_a),
    .channel_out(chan_a), .frame_done(fd_a), .frame_err(fe_a));

  rhs_spi_emulator #(.N_CHIPS(4), .SEED_STRIDE(65535), .PIPE_DEPTH(1), .REG_DEPTH(32),
                     .CHIP_ID(16'h0020)) dut_b (
    .clk(clk), .rst(rst), .SCLK(sclk), .CS(cs), .MOSI(mosi[3:0]), .MISO(miso_b),
    .channel_out(chan_b), .frame_done(fd_b), .frame_err(fe_b));

  rhs_spi_emulator #(.N_CHIPS(4), .SEED_STRIDE(16), .PIPE_DEPTH(3), .REG_DEPTH(32),
                     .CHIP_ID(16'h0020)) dut_c (
    .clk(clk), .rst(rst), .SCLK(sclk), .CS(cs), .MOSI(mosi[3:0]), .MISO(miso_c),
    .channel_out(chan_c), .frame_done(fd_c), .frame_err(fe_c));

  int fd_cnt [3] = '{0, 0, 0};
  int fe_cnt [3] = '{0, 0, 0};

  always @(posedge clk) begin
    if (fd_a) fd_cnt[0]++;
    if (fd_b) fd_cnt[1]++;
    if (fd_c) fd_cnt[2]++;
    if (fe_a) fe_cnt[0]++;
    if (fe_b) fe_cnt[1]++;
    if (fe_c) fe_cnt[2]++;
  end

  logic [15:0]       m_samp [3][16][16];
  logic [15:0]       m_regs [3][16][32];
  logic [5:0]        m_chan [3][16];
  logic [15:0][31:0] exp_q  [3][$];
  logic [31:0]       cmd    [16];
  logic [31:0]       cap    [3][16];
  int total = 0;
  int bad   = 0;
  int frame_no = 0;

  function automatic int pd(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
  endfunction
  function automatic int nc(int d);
    return (d == 0) ? 16 : 4;
  endfunction
  function automatic int stride(int d);
    return (d == 1) ? 65535 : 16;
  endfunction

  function automatic logic get_miso(int d, int c);
    logic [3:0] ci;
    ci = 4'(c);
    if (d == 0) return miso_a[ci];
    if (d == 1) return miso_b[ci[1:0]];
    return miso_c[ci[1:0]];
  endfunction

  function automatic logic [5:0] get_chan(int d, int c);
    if (d == 0) return chan_a[c*6 +: 6];
    if (d == 1) return chan_b[c*6 +: 6];
    return chan_c[c*6 +: 6];
  endfunction

  function automatic logic [31:0] f_conv(int ch);
    return {8'h00, 2'b00, 6'(ch), 16'h0000};
  endfunction
  function automatic logic [31:0] f_wr(int a, logic [15:0] dat);
    return {8'h80, 8'(a), dat};
  endfunction
  function automatic logic [31:0] f_rd(int a);
    return {8'hC0, 8'(a), 16'h0000};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    logic [15:0][31:0] zero;
    zero = '0;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 16; c++) begin
        for (int ch = 0; ch < 16; ch++) m_samp[d][c][ch] = 16'(c * stride(d) + ch);
        for (int a = 0; a < 32; a++) m_regs[d][c][a] = '0;
        m_chan[d][c] = '0;
      end
      exp_q[d].delete();
      for (int k = 0; k < pd(d); k++) exp_q[d].push_back(zero);
    end
  endtask

  task automatic model_exec(input int d, input int c, input logic [31:0] w,
                            output logic [31:0] r);
    int a, ch;
    a  = int'(w[23:16]);
    ch = int'(w[21:16]);
    r  = '0;
    case (w[31:30])
      2'b00: if (ch < 16) begin
        r = {16'h0000, m_samp[d][c][ch]};
        m_samp[d][c][ch] = m_samp[d][c][ch] + 16'd1;
        m_chan[d][c] = 6'(ch);
      end
      2'b10: begin
        r = {16'hFFFF, w[15:0]};
        if (a < 32) m_regs[d][c][a] = w[15:0];
      end
      2'b11: begin
        if (a == 255) r = 32'h0000_0020;
        else if (a < 32) r = {16'h0000, m_regs[d][c][a]};
      end
      default: if (w[31:24] == 8'h6A) begin
        for (int k = 0; k < 16; k++) m_samp[d][c][k] = 16'(c * stride(d) + k);
      end
    endcase
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " miso_a"}, 32'(miso_a), 32'h0);
    check({tag, " miso_bc"}, 32'({miso_b, miso_c}), 32'h0);
    check({tag, " chan"}, 32'({|chan_a, |chan_b, |chan_c}), 32'h0);
    check({tag, " done_err"}, 32'({fd_a, fe_a, fd_b, fe_b, fd_c, fe_c}), 32'h0);
  endtask

  // One SPI frame: nbits SCLK pulses; rst is pulsed before bit rst_at if >= 0.
  task automatic run_frame(input int nbits, input int rst_at);
    int fd0 [3];
    int fe0 [3];
    logic accepted;
    logic [15:0][31:0] ent, res;
    logic [31:0] r;
    for (int d = 0; d < 3; d++) begin
      fd0[d] = fd_cnt[d];
      fe0[d] = fe_cnt[d];
    end
    cs = 1'b0;
    wait_clks(8);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 16; c++) mosi[c] = (i < 32) ? cmd[c][31-i] : 1'b0;
      wait_clks(4);
      if (i < 32) begin
        for (int d = 0; d < 3; d++)
          for (int c = 0; c < nc(d); c++) cap[d][c][31-i] = get_miso(d, c);
      end
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(1);
        reset_checks($sformatf("midrst f%0d", frame_no));
        model_reset();
      end
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
    wait_clks(4);
    cs = 1'b1;
    wait_clks(8);
    accepted = (nbits == 32) && (rst_at < 0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("done d%0d f%0d", d, frame_no), 32'(fd_cnt[d] - fd0[d]),
            accepted ? 32'd1 : 32'd0);
      check($sformatf("err d%0d f%0d", d, frame_no), 32'(fe_cnt[d] - fe0[d]),
            (!accepted && rst_at < 0) ? 32'd1 : 32'd0);
    end
    if (accepted) begin
      for (int d = 0; d < 3; d++) begin
        ent = exp_q[d].pop_front();
        res = '0;
        for (int c = 0; c < nc(d); c++) begin
          check($sformatf("miso d%0d c%0d f%0d", d, c, frame_no), cap[d][c], ent[c]);
          model_exec(d, c, cmd[c], r);
          res[c] = r;
        end
        exp_q[d].push_back(res);
        for (int c = 0; c < nc(d); c++)
          check($sformatf("chan d%0d c%0d f%0d", d, c, frame_no),
                32'(get_chan(d, c)), 32'(m_chan[d][c]));
      end
    end
    frame_no++;
  endtask

  task automatic set_all(input logic [31:0] w);
    for (int c = 0; c < 16; c++) cmd[c] = w;
  endtask

  initial begin
    wait_clks(3);
    reset_checks("reset");
    rst = 1'b0;
    model_reset();
    wait_clks(2);

    // Frames 0..3: chip 2 converts ch 5, the others mixed channels incl. >= 16.
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 16; c++) cmd[c] = (c == 2) ? f_conv(5) : f_conv((c * 3 + f) % 20);
      run_frame(32, -1);
    end
    check("conv chan_a2", 32'(get_chan(0, 2)), 32'd5);
    check("conv f3 a2", cap[0][2], 32'h0000_0026);

    set_all(f_wr(3, 16'hBEEF));
    cmd[5] = f_wr(40, 16'h1234);
    run_frame(32, -1);
    check("conv f4 a2", cap[0][2], 32'h0000_0027);
    set_all(f_rd(3));
    run_frame(32, -1);
    check("conv f5 a2", cap[0][2], 32'h0000_0028);
    set_all(f_rd(255));
    run_frame(32, -1);
    check("write f6 a2", cap[0][2], 32'hFFFF_BEEF);
    set_all(f_rd(40));
    run_frame(32, -1);
    check("read3 f7 a2", cap[0][2], 32'h0000_BEEF);

    // Short frame is discarded; pipeline must carry on unaffected.
    set_all(f_conv(5));
    run_frame(20, -1);
    for (int c = 0; c < 16; c++) cmd[c] = c[0] ? f_rd(3) : 32'h4000_0000;
    run_frame(32, -1);
    check("read255 f9 a2", cap[0][2], 32'h0000_0020);

    // dut_b chip 1 channel 0 seeds at FFFF: wrap, then CLEAR restores the seed.
    set_all(f_conv(0));
    run_frame(32, -1);
    run_frame(32, -1);
    check("wrap ffff b1", cap[1][1], 32'h0000_FFFF);
    set_all(32'h6A00_0000);
    run_frame(32, -1);
    check("wrap 0000 b1", cap[1][1], 32'h0000_0000);
    set_all(f_conv(0));
    run_frame(32, -1);
    set_all(32'h4000_0000);
    run_frame(32, -1);
    check("clear seed b1", cap[1][1], 32'h0000_FFFF);

    // Long frame, then reset mid-frame, then the reset pipeline value.
    set_all(f_conv(1));
    run_frame(36, -1);
    set_all(f_rd(3));
    run_frame(32, 17);
    set_all(f_conv(9));
    run_frame(32, -1);
    check("post rst a0", cap[0][0], 32'h0);
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 16; c++) cmd[c] = f_conv((c + f) % 16);
      run_frame(32, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rhs_spi_emulator.md
RHS_SPI_EMULATOR -- requirements
Module: rhs_spi_emulator

Interface
REQ-001 Parameter N_CHIPS, default 16, number of emulated RHS chips (1..16).
REQ-002 Parameter SEED_STRIDE, default 16, sample-seed spacing between chips.
REQ-003 Parameter PIPE_DEPTH, default 2, command-to-result latency in frames (1..3).
REQ-004 Parameter REG_DEPTH, default 32, implemented registers per chip (power of 2, <=128).
REQ-005 Parameter CHIP_ID, default 16'h0020, value returned by a read of register 255.
REQ-006 clk  in  1  system clock; the only clock; runs at least 4x SCLK.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 SCLK  in  1  SPI clock from the master; asynchronous to clk.
REQ-009 CS  in  1  active-low chip select, shared by all chips.
REQ-010 MOSI  in  N_CHIPS  per-chip command lines.
REQ-011 MISO  out  N_CHIPS  per-chip result lines.
REQ-012 channel_out  out  N_CHIPS*6  last CONVERT channel per chip.
REQ-013 frame_done  out  1  one-clk pulse per accepted 32-bit frame.
REQ-014 frame_err  out  1  one-clk pulse per discarded short or long frame.

Function
REQ-015 SCLK, CS and MOSI SHALL pass through 2-FF synchronisers; edge detection SHALL use the synchronised signals only.
REQ-016 The frame format SHALL be SPI mode 0, MSB first, 32 bits: MOSI sampled on synchronised SCLK rise, MISO updated on synchronised SCLK fall.
REQ-017 While CS is low, MISO SHALL present bit 31 from the first clk after the CS fall; while CS is high, MISO SHALL be 0.
REQ-018 A CS rise with the bit count equal to 32 SHALL accept the frame; any other count SHALL discard it, pulse frame_err and leave the pipeline unchanged.
REQ-019 Decode SHALL use cmd[31:30]: 00 CONVERT (channel cmd[21:16]); 10 WRITE (addr cmd[23:16], data cmd[15:0]); 11 READ (addr cmd[23:16]); 01 with cmd[31:24]=8'h6A CLEAR; any other code is a NOP.
REQ-020 A CONVERT result SHALL be {16'h0000, sample[chip][ch]}; the sample SHALL then increment modulo 2^16, wrapping FFFF->0000.
REQ-021 A CONVERT with a channel of 16 or more SHALL return 32'h0 and leave samples and channel_out unchanged.
REQ-022 A WRITE result SHALL be {16'hFFFF, data}; the write SHALL be stored if addr < REG_DEPTH and otherwise ignored.
REQ-023 A READ result SHALL be {16'h0000, reg}; it SHALL return CHIP_ID for addr 255 and 0 for any other addr >= REG_DEPTH.
REQ-024 A CLEAR result SHALL be 32'h0; CLEAR SHALL reload all samples of that chip to seed values; NOP results SHALL be 32'h0.
REQ-025 The result of accepted frame k SHALL be shifted out during accepted frame k+PIPE_DEPTH; before it exists, MISO SHALL shift 32'h0.
REQ-026 The command executes on the clk of frame acceptance; a READ in frame k+1 SHALL observe a WRITE from frame k.
REQ-027 frame_done SHALL pulse on the acceptance clk.
REQ-028 channel_out SHALL update on that same clk for valid CONVERTs.
REQ-029 Chips SHALL operate independently on their own MOSI within the shared CS/SCLK frame.

Reset
REQ-030 On rst: MISO=0, channel_out=0, frame_done=0, frame_err=0, bit counters and synchronisers cleared.
REQ-031 On rst: result pipeline filled with 32'h0, registers cleared, sample[c][ch] = c*SEED_STRIDE + ch.
REQ-032 rst asserted mid-frame SHALL abort the frame without a frame_err; the next CS fall starts a clean frame.

Structure
REQ-033 Package rhs_pkg SHALL hold the opcode constants, CLEAR_KEY 8'h6A, CHANNELS_PER_CHIP=16, FRAME_BITS=32 and REG_CHIP_ID_ADDR=255.
REQ-034 The top SHALL hold the synchronisers, bit counter and framing.
REQ-035 A generate loop SHALL instantiate N_CHIPS copies of sub-module rhs_spi_emu_chip, each containing the shift registers, decode, register file, sample counters and result pipeline.

Verification
REQ-036 Bench: CONVERT ch 5 to chip 2 (SEED_STRIDE=16) for frames 0..3 -> MISO frames 2..5 = 0x25, 0x26, 0x27, 0x28; channel_out[2] = 5.
REQ-037 Bench: WRITE addr 3 data 0xBEEF, then READ 3, READ 255, READ 40 -> results 0xFFFFBEEF, 0x0000BEEF, 0x00000020, 0x00000000.
REQ-038 Bench: CS raised after 20 bits -> frame_err pulses once, no frame_done, and the next result is unaffected.
REQ-039 Bench: preload a sample to 0xFFFF, then CONVERT twice -> 0xFFFF, 0x0000; CLEAR, then CONVERT -> seed value.
REQ-040 Bench: PIPE_DEPTH=1, 3 and N_CHIPS=4 sweep -> results appear exactly PIPE_DEPTH frames later, with 16 chips driven independently.
REQ-041 Bench: rst pulsed at bit 17 of a frame -> all outputs 0, no frame_err, and the next frame returns the reset pipeline value 0.
